// File: rtl/hack_pkg.sv
// hack_pkg: shared FSM encoding and RAM geometry for the RAM dump block
package hack_pkg;

    localparam int RAM_DEPTH = 3840;
    localparam int WORD_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HI,
        S_LO,
        S_DONE
    } state_e;

endpackage

// File: rtl/ram_dump.sv
// ram_dump: reads a word range from the data RAM and streams it out high byte first
module ram_dump
    import hack_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH,
    parameter int AW    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base,
    input  logic [AW-1:0]     count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     mem_address,
    output logic              mem_load,
    input  logic [WORD_W-1:0] mem_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       rem_q, rem_d;
    logic                err_q, err_d;
    logic [AW:0]         end_addr;
    logic                in_range;

    assign end_addr = {1'b0, base} + {1'b0, count};
    assign in_range = end_addr <= (AW+1)'(DEPTH);

    // state and datapath registers; reset also abandons any word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // next-state: request checking, word fetch, two-byte handshake, completion
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = S_DONE;
                    end else if (in_range) begin
                        addr_d  = base;
                        rem_d   = count;
                        state_d = S_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                word_d  = mem_out;
                state_d = S_HI;
            end
            S_HI: begin
                if (tx_ready) state_d = S_LO;
            end
            S_LO: begin
                if (tx_ready) begin
                    if (rem_q == AW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                addr_d  = '0;
                rem_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decode registered state only, so tx_ready never reaches an output
    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_DONE;
    assign err         = err_q;
    assign mem_address = addr_q;
    assign mem_load    = 1'b0;
    assign tx_valid    = (state_q == S_HI) || (state_q == S_LO);
    assign tx_data     = (state_q == S_HI) ? word_q[15:8] :
                         (state_q == S_LO) ? word_q[7:0]  : 8'h00;

endmodule

// File: tb/tb_ram_dump.sv
// tb_ram_dump: directed self-checking bench for ram_dump
module tb_ram_dump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [15:0] count = '0;
    logic        tx_ready = 1'b0;
    logic        busy, done, err, mem_load, tx_valid;
    logic [15:0] mem_address, mem_out;
    logic [7:0]  tx_data;

    logic [15:0] ram [0:3839];
    logic [7:0]  got [$];
    logic [7:0]  exp6 [6];
    int          n_chk = 0;
    int          n_pass = 0;
    int          first_v, done_c, last_hs, stall_bad, err_seen;

    always #5 clk = ~clk;

    assign mem_out = (mem_address < 16'd3840) ? ram[mem_address] : 16'hDEAD;

    ram_dump dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base(base),
        .count(count),
        .busy(busy),
        .done(done),
        .err(err),
        .mem_address(mem_address),
        .mem_load(mem_load),
        .mem_out(mem_out),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // returns at the negedge of cycle N+1, where edge N accepted the request
    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // drives tx_ready, collects bytes and timing from cycle N+1 onward
    task automatic run(input bit rnd, input int inj);
        logic       pend;
        logic [7:0] pd;
        got.delete();
        first_v = -1; done_c = -1; last_hs = -1; stall_bad = 0; err_seen = 0;
        pend = 1'b0; pd = '0;
        for (int k = 1; k <= 200; k++) begin
            if (pend && !(tx_valid && tx_data == pd)) stall_bad++;
            if (err) err_seen++;
            if (tx_valid && first_v < 0) first_v = k;
            if (done) begin
                done_c = k;
                break;
            end
            start = (k == inj);
            if (k == inj) begin
                base  = 16'd200;
                count = 16'd1;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pend = tx_valid && !tx_ready;
            pd   = tx_data;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                last_hs = k;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(done_c > 0), 1);
    endtask

    task automatic check_six(input string tag);
        check({tag, "_len"}, got.size(), 6);
        for (int i = 0; i < 6; i++)
            check({tag, "_byte"}, (i < got.size()) ? got[i] : 8'hxx, exp6[i]);
    endtask

    initial begin
        for (int i = 0; i < 3840; i++) ram[i] = 16'(i * 7);
        ram[10]   = 16'h1234;
        ram[11]   = 16'hABCD;
        ram[12]   = 16'h00FF;
        ram[200]  = 16'h5A5A;
        ram[3839] = 16'hBEEF;
        exp6 = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_addr", mem_address, 0);
        check("rst_load", mem_load, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_start(16'd10, 16'd3);
        check("fetch_busy", busy, 1);
        check("fetch_valid", tx_valid, 0);
        check("fetch_addr", mem_address, 10);
        run(1'b0, 0);
        check_six("full");
        check("first_valid", first_v, 2);
        check("done_cycle", done_c, 10);
        check("done_after_hs", done_c, last_hs + 1);
        check("done_busy", busy, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_addr", mem_address, 0);

        do_start(16'd10, 16'd3);
        run(1'b1, 0);
        check_six("stall");
        check("stall_stable", stall_bad, 0);
        check("stall_done_after_hs", done_c, last_hs + 1);
        @(negedge clk);

        do_start(16'd3839, 16'd1);
        run(1'b0, 0);
        check("edge_len", got.size(), 2);
        check("edge_hi", (got.size() > 0) ? got[0] : 8'hxx, 8'hBE);
        check("edge_lo", (got.size() > 1) ? got[1] : 8'hxx, 8'hEF);
        @(negedge clk);

        do_start(16'd3839, 16'd2);
        check("ovf_err", err, 1);
        check("ovf_busy", busy, 0);
        check("ovf_valid", tx_valid, 0);
        @(negedge clk);
        check("ovf_err_pulse", err, 0);
        check("ovf_busy2", busy, 0);
        check("ovf_valid2", tx_valid, 0);

        do_start(16'd5, 16'd0);
        check("zero_done", done, 1);
        check("zero_valid", tx_valid, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_busy", busy, 0);
        check("zero_valid2", tx_valid, 0);

        do_start(16'd10, 16'd3);
        run(1'b0, 2);
        check_six("ign");
        check("ign_err", err_seen, 0);
        check("ign_done_cycle", done_c, 10);
        @(negedge clk);
        check("ign_idle", busy, 0);

        tx_ready = 1'b1;
        do_start(16'd10, 16'd3);
        @(negedge clk);
        check("pre_hi", tx_data, 8'h12);
        @(negedge clk);
        tx_ready = 1'b0;
        check("pre_lo", tx_data, 8'h34);
        check("pre_addr", mem_address, 10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", tx_valid, 0);
        check("arst_data", tx_data, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", mem_address, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_done", done, 0);
        do_start(16'd200, 16'd1);
        run(1'b0, 0);
        check("post_len", got.size(), 2);
        check("post_hi", (got.size() > 0) ? got[0] : 8'hxx, 8'h5A);
        check("post_lo", (got.size() > 1) ? got[1] : 8'hxx, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_dump.md
# ram_dump

Bus-initiator block that reads a contiguous range of 16-bit words from the 3840-word data RAM and serializes them as a byte stream, high byte first, over a valid/ready handshake. It sits between the RAM's read port and a byte-oriented sink such as a UART transmitter or SD writer. While busy it owns the RAM address lines through an external mux selected by `busy`. It never writes memory.

## Interface
- `DEPTH`, 3840: number of valid RAM words; legal addresses are 0..DEPTH-1.
- `AW`, 16: width of the address and count fields.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `base`  in  AW  first word address; sampled with `start`.
- `count`  in  AW  number of words to dump; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE exits; selects this block onto the RAM port.
- `done`  out  1  one-cycle pulse when a dump completes.
- `err`  out  1  one-cycle pulse when a request is rejected.
- `mem_address`  out  16  RAM word address; registered.
- `mem_load`  out  1  constant 0.
- `mem_out`  in  16  RAM read data; combinational function of `mem_address`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid` and `tx_ready` are both high on a rising edge.

## Operation
- States: IDLE, FETCH, HI, LO, DONE.
- **IDLE**
  - On `start`, with `count` nonzero and `base + count` ≤ DEPTH (sum computed at AW+1 bits): latch `mem_address <= base` and `remaining <= count`, then go to FETCH.
  - On `start` with `count` = 0: go directly to DONE.
  - On `start` with the range exceeding DEPTH: pulse `err` next cycle and stay in IDLE.
- **FETCH**: capture `word <= mem_out`, then go to HI.
- **HI**: `tx_valid`=1, `tx_data` = `word[15:8]`. Hold until handshake, then go to LO.
- **LO**: `tx_valid`=1, `tx_data` = `word[7:0]`. On handshake:
  - if `remaining` = 1, go to DONE;
  - otherwise `mem_address++`, `remaining--`, go to FETCH.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- `start` in any state other than IDLE is ignored (not queued, no `err`).
- `tx_data` and `tx_valid` stay stable while stalled. `tx_valid` never drops without a handshake.
- `mem_address` returns to 0 on entry to IDLE.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `tx_valid` = 0; `tx_data`, `mem_address`, `word`, `remaining` = 0; `mem_load` = 0 always.
- All outputs are registered or decoded from registered state only. No combinational path from `tx_ready` to any output.
- Start accepted at edge N: FETCH during cycle N+1, first `tx_valid` in cycle N+2.
- Steady state with `tx_ready` held high: 3 cycles per word (FETCH, HI, LO).
- Last LO handshake at edge M: `done` high in cycle M+1, `busy` low from cycle M+2.
- `count` = 0: `done` in cycle N+1, no bytes emitted.
- Reset asserted mid-dump: immediate return to IDLE with reset values. A partially sent word is lost and no `done` is generated.
- `base` + `count` = DEPTH exactly is legal; the last address read is DEPTH-1.

## Structure
- Shared package `hack_pkg`: state enum encoding, `RAM_DEPTH` = 3840, `WORD_W` = 16.
- Single flat module. The byte serializer (HI/LO) is small enough to stay inline; no sub-module.

## Test plan
- Preload RAM[10..12] = 16'h1234, 16'hABCD, 16'h00FF. Start with base=10, count=3, `tx_ready`=1 → bytes 12,34,AB,CD,00,FF; first `tx_valid` 2 cycles after start; `done` 1 cycle after the last handshake.
- Same dump with `tx_ready` toggled randomly → identical byte sequence; `tx_data` stable during every stall.
- Start with base=3839, count=1 → bytes from RAM[3839] only. Start with base=3839, count=2 → `err` pulse, no `busy`, no bytes.
- Start with count=0 → `done` pulse in cycle N+1; `tx_valid` never asserted.
- `start` pulsed during HI with a different base → ignored; the original dump completes unchanged.
- Deassert `rst_n` asynchronously mid-LO → all outputs 0 immediately. A fresh start afterwards dumps correctly from its own base.
